// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop synchroniser per channel, a
// shared sample-tick prescaler, a per-channel stability counter and auto-repeat.
module debounce_multi #(
    parameter int unsigned         CHANNELS     = 4,
    parameter int unsigned         TICK_DIV     = 250000,
    parameter int unsigned         STABLE_TICKS = 3,
    parameter int unsigned         REPEAT_DELAY = 8,
    parameter int unsigned         REPEAT_RATE  = 2,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_btn,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_repeat,
    output logic                o_tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);

    localparam logic [CW-1:0] TickLast  = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StabLast  = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] RptLast   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RptReload = RW'(REPEAT_DELAY - REPEAT_RATE);
    // Only reachable with REPEAT_RATE == 0: the counter parks here after one repeat.
    localparam logic [RW-1:0] RptSat    = RW'(REPEAT_DELAY);

    if (REPEAT_RATE > REPEAT_DELAY) begin : g_bad_rate
        $error("REPEAT_RATE must not exceed REPEAT_DELAY");
    end

    logic [CHANNELS-1:0] sync1_q, sync_q;
    logic [CW-1:0]       div_q, div_d;
    logic                tick, tick_q;
    logic [SW-1:0]       stab_q [CHANNELS];
    logic [SW-1:0]       stab_d [CHANNELS];
    logic [RW-1:0]       rpt_q  [CHANNELS];
    logic [RW-1:0]       rpt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;

    assign tick = (div_q == TickLast);

    // Prescaler next count: wrap to 0 after the terminal count.
    always_comb begin
        div_d = tick ? '0 : div_q + CW'(1);
    end

    // Per-channel stability filter and auto-repeat next state.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            stab_d[ch] = stab_q[ch];
            rpt_d[ch]  = rpt_q[ch];
            if (tick) begin
                if (sync_q[ch] == level_q[ch]) begin
                    stab_d[ch] = '0;
                end else if (stab_q[ch] == StabLast) begin
                    level_d[ch]   = sync_q[ch];
                    stab_d[ch]    = '0;
                    press_d[ch]   = sync_q[ch];
                    release_d[ch] = ~sync_q[ch];
                end else begin
                    stab_d[ch] = stab_q[ch] + SW'(1);
                end
            end
            // A committing release suppresses any repeat on the same tick.
            if (!level_q[ch]) begin
                rpt_d[ch] = '0;
            end else if (tick) begin
                if (release_d[ch]) begin
                    rpt_d[ch] = '0;
                end else if (rpt_q[ch] == RptLast) begin
                    repeat_d[ch] = 1'b1;
                    rpt_d[ch]    = RptReload;
                end else if (rpt_q[ch] != RptSat) begin
                    rpt_d[ch] = rpt_q[ch] + RW'(1);
                end
            end
        end
    end

    // All state and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            div_q     <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                stab_q[ch] <= '0;
                rpt_q[ch]  <= '0;
            end
        end else begin
            sync1_q   <= i_btn ^ ACTIVE_LOW;
            sync_q    <= sync1_q;
            div_q     <= div_d;
            tick_q    <= tick;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                stab_q[ch] <= stab_d[ch];
                rpt_q[ch]  <= rpt_d[ch];
            end
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;
    assign o_tick    = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: expected pulse events are queued with their cycle
// when stimulus is driven and matched by a monitor as the DUT pulses.
module tb_debounce_multi;

    localparam int KPress   = 0;
    localparam int KRelease = 1;
    localparam int KRepeat  = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_btn = 4'b1000;
    logic [3:0] o_level, o_press, o_release, o_repeat;
    logic       o_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } evt_t;

    evt_t sb[$];

    debounce_multi #(
        .CHANNELS    (4),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE (2),
        .ACTIVE_LOW  (4'b1000)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_repeat (o_repeat),
        .o_tick   (o_tick)
    );

    always #5 clk = ~clk;

    // Edge index since the last reset edge; edge k leaves cyc == k.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input int c, input int k, input int ch);
        return {c[15:0], k[7:0], ch[7:0]};
    endfunction

    task automatic push(input int c, input int k, input int ch);
        evt_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse monitor: every pulse must match the queue head; overdue entries fail.
    always @(negedge clk) begin
        logic [3:0]  vec;
        logic [31:0] exp;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed", 32'hffff_ffff, pack(sb[0].cyc, sb[0].kind, sb[0].ch));
            void'(sb.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            case (k)
                KPress:   vec = o_press;
                KRelease: vec = o_release;
                default:  vec = o_repeat;
            endcase
            for (int ch = 0; ch < 4; ch++) begin
                if (vec[ch] === 1'b1) begin
                    exp = (sb.size() > 0) ? pack(sb[0].cyc, sb[0].kind, sb[0].ch) : 32'h0;
                    check("pulse", pack(cyc, k, ch), exp);
                    if (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // 1. Reset and idle, ch3 idle-high
        repeat (3) @(negedge clk);
        check("rst_out", 32'({o_level, o_press, o_release, o_repeat, o_tick}), 32'h0);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            wait_to(c);
            check("tick", 32'(o_tick), 32'((c % 4) == 0));
        end
        check("idle_lvl", 32'(o_level), 32'h0);

        // 2. Clean press/release on ch0
        wait_to(20);
        i_btn[0] = 1'b1;
        push(32, KPress, 0);
        wait_to(31);
        check("lvl0_pre", 32'(o_level[0]), 32'h0);
        wait_to(32);
        check("lvl0_set", 32'(o_level[0]), 32'h1);
        wait_to(40);
        i_btn[0] = 1'b0;
        push(52, KRelease, 0);
        wait_to(51);
        check("lvl0_hold", 32'(o_level[0]), 32'h1);
        wait_to(52);
        check("lvl0_clr", 32'(o_level[0]), 32'h0);

        // 3. Bounce rejection on ch1, then a stable press
        for (int i = 0; i < 8; i++) begin
            wait_to(60 + 4 * i);
            i_btn[1] = (i % 2 == 0);
        end
        wait_to(92);
        check("lvl1_bounce", 32'(o_level[1]), 32'h0);
        i_btn[1] = 1'b1;
        push(104, KPress, 1);
        wait_to(103);
        check("lvl1_pre", 32'(o_level[1]), 32'h0);
        wait_to(104);
        check("lvl1_set", 32'(o_level[1]), 32'h1);
        wait_to(110);
        i_btn[1] = 1'b0;
        push(124, KRelease, 1);

        // 4. Auto-repeat on ch2; release lands on a would-be repeat tick
        wait_to(130);
        i_btn[2] = 1'b1;
        push(144, KPress, 2);
        push(164, KRepeat, 2);
        push(172, KRepeat, 2);
        push(180, KRepeat, 2);
        wait_to(184);
        i_btn[2] = 1'b0;
        push(188, KRepeat, 2);
        push(196, KRelease, 2);
        wait_to(200);
        check("lvl2_clr", 32'(o_level[2]), 32'h0);

        // 5. Active-low ch3 and ch0 pressed together
        wait_to(210);
        i_btn[0] = 1'b1;
        i_btn[3] = 1'b0;
        push(224, KPress, 0);
        push(224, KPress, 3);
        wait_to(224);
        check("lvl_pair", 32'(o_level), 32'h9);
        wait_to(230);
        i_btn[0] = 1'b0;
        i_btn[3] = 1'b1;
        push(244, KRelease, 0);
        push(244, KRelease, 3);

        // 6. Reset mid-debounce (ch0) and mid-hold (ch2)
        wait_to(250);
        i_btn[2] = 1'b1;
        push(264, KPress, 2);
        wait_to(270);
        i_btn[0] = 1'b1;
        wait_to(281);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid", 32'({o_level, o_press, o_release, o_repeat, o_tick}), 32'h0);
        check("sb_at_rst", 32'(sb.size()), 32'h0);
        rst_n = 1'b1;
        push(12, KPress, 0);
        push(12, KPress, 2);
        wait_to(4);
        check("tick_rst", 32'(o_tick), 32'h1);
        wait_to(11);
        check("lvl_rst_pre", 32'(o_level), 32'h0);
        wait_to(12);
        check("lvl_rst_set", 32'(o_level), 32'h5);
        wait_to(20);
        i_btn[0] = 1'b0;
        i_btn[2] = 1'b0;
        push(32, KRelease, 0);
        push(32, KRelease, 2);
        wait_to(60);
        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner, successor to the single-channel debouncer.
- Synchronises N raw button inputs to clk and filters each one with a shared sample-tick prescaler plus a per-channel stability counter.
- Produces a debounced level and one-cycle press, release and auto-repeat pulses per channel.
- Sits between board button pins and UI/control logic.

Parameters:
- CHANNELS, 4: number of independent button channels (>=1).
- TICK_DIV, 250000: clk cycles per sample tick (>=2).
- STABLE_TICKS, 3: consecutive disagreeing ticks needed to change the debounced level (>=1).
- REPEAT_DELAY, 8: ticks from press to first auto-repeat pulse (>=1).
- REPEAT_RATE, 2: ticks between subsequent repeat pulses; 0 disables auto-repeat.
- ACTIVE_LOW, 0: CHANNELS-bit mask; a set bit inverts that channel's raw input (pin low = pressed).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_btn  in  CHANNELS  raw asynchronous button inputs
- o_level  out  CHANNELS  debounced pressed state, 1 = pressed
- o_press  out  CHANNELS  one-cycle pulse on a 0->1 debounced transition
- o_release  out  CHANNELS  one-cycle pulse on a 1->0 debounced transition
- o_repeat  out  CHANNELS  one-cycle auto-repeat pulse while held
- o_tick  out  1  one-cycle sample-tick strobe, exported for debug and UI timing

Behaviour:
- Reset: one clock, synchronous active-low reset; rst_n is sampled on posedge clk.
- While rst_n=0:
  - all outputs are 0;
  - prescaler, stability and repeat counters are 0;
  - synchroniser flops are loaded with the de-asserted (not pressed) value.
  - Reset asserted mid-debounce or mid-hold abandons the operation with no pulse.
- Input path:
  - raw input XOR ACTIVE_LOW[ch];
  - then a 2-flop synchroniser; s[ch] is the second flop.
  - Latency from a pin edge to s is 2 cycles.
- Prescaler:
  - counter width $clog2(TICK_DIV); counts 0..TICK_DIV-1, then wraps to 0.
  - Tick is asserted combinationally when count == TICK_DIV-1; compare by equality only.
  - o_tick is the registered tick, so it is high in the cycle after the terminal count.
  - The first terminal count is the TICK_DIV-th cycle after reset release.
- Stability counter, per channel, width $clog2(STABLE_TICKS+1):
  - Updates only on a tick.
  - s == o_level: counter <= 0.
  - s != o_level and counter+1 < STABLE_TICKS: counter <= counter+1.
  - s != o_level and counter+1 == STABLE_TICKS: o_level <= s, counter <= 0, and o_press or o_release fires in the same registered cycle as the level change.
  - Any single tick on which s agrees with o_level discards the accumulated count (glitch rejection).
- Auto-repeat, per channel, counter width $clog2(REPEAT_DELAY+1):
  - Cleared whenever o_level is 0 or a press occurs.
  - On each tick while o_level=1 and no release is committing: rpt+1.
  - When rpt+1 == REPEAT_DELAY: o_repeat pulses and rpt <= REPEAT_DELAY-REPEAT_RATE, so subsequent pulses come every REPEAT_RATE ticks.
  - REPEAT_RATE=0: exactly one repeat after REPEAT_DELAY, then the counter saturates.
  - REPEAT_RATE > REPEAT_DELAY is illegal (elaboration-time assertion).
- Simultaneous events:
  - Channels are fully independent; multiple channels may pulse in the same cycle.
  - A release and a would-be repeat on the same tick: release wins, no repeat.
  - o_press and o_repeat never fire in the same cycle.
- Pulse width:
  - Every pulse is exactly 1 clk cycle, one pulse per event.
  - Outputs are registered; no combinational path from i_btn.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, CHANNELS=4, ACTIVE_LOW=4'b1000):
1. Reset and idle: rst_n=0 for 3 cycles, i_btn=4'b1000 (ch3 idle-high) -> all outputs 0; o_tick first high in cycle 5 after release, then every 4 cycles.
2. Clean press/release on ch0: hold i_btn[0]=1 -> o_level[0] rises on the 3rd tick after s[0] goes high, with a single 1-cycle o_press[0]; drop the input -> o_level[0] falls on the 3rd tick, with a single o_release[0].
3. Bounce rejection on ch1: toggle i_btn[1] so that s agrees with o_level on every 2nd tick -> o_level[1] stays 0 and no pulses fire; then hold stable -> press after 3 ticks.
4. Auto-repeat on ch2: hold pressed -> o_repeat[2] at 5 ticks after press, then at 7, 9, 11 ticks; release on the tick a repeat would fire -> o_release only, no o_repeat.
5. Polarity and concurrency: drive ch3 low and ch0 high at the same edge -> o_press[3] and o_press[0] assert in the same cycle.
6. Reset mid-operation: assert rst_n=0 two ticks into a ch0 debounce and while ch2 is held -> no pulses; after release, debounce restarts from count 0.
